grant_decoder: RTL and testbench
================================

Name: grant_decoder

Overview:
Sequential 2-to-4 decoder on the consumer side of the priority encoder interface. It accepts an encoded index plus valid through a valid/ready handshake and drives the matching one-hot grant line for a fixed hold window. A guard gap of idle cycles follows each grant. It sits between the priority-encoded request path and the resource-select lines, converting (out, valid) back into a timed one-hot grant.

Parameters:
N_OUT, 4, number of one-hot grant lines (2..16)
IDX_W, $clog2(N_OUT), index width (derived; 2 for the default)
HOLD_CYCLES, 4, cycles a grant stays asserted unless released early (1..255)
GAP_CYCLES, 1, idle cycles after a grant before the next acceptance (0..255)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_idx  input  IDX_W  encoded index from the priority encoder
in_valid  input  1  in_idx is valid
in_ready  output  1  decoder can accept an index this cycle
release  input  1  grantee returns the grant early
grant  output  N_OUT  registered one-hot grant
busy  output  1  state is not IDLE
err  output  1  one-cycle pulse when an out-of-range index is accepted

Behaviour:
- One clock; reset is asynchronous and active-low (clk, rst_n).
- While rst_n=0: state=IDLE, grant=0, err=0, busy=0, in_ready=1, counters=0.
- Reset mid-grant clears grant to 0 asynchronously. No partial hold or gap resumes after reset.
- FSM states: IDLE, GRANT, GAP.
- in_ready is 1 only in IDLE. It is a combinational decode of the state register and does not depend on in_valid.
- Acceptance: in_valid & in_ready on a rising edge.
- IDLE, acceptance with in_idx < N_OUT:
  - next cycle: state=GRANT, grant[in_idx]=1 and all other bits 0, hold counter = HOLD_CYCLES-1.
  - Latency from accept edge to grant visible is 1 cycle.
- IDLE, acceptance with in_idx >= N_OUT (possible only when N_OUT is not a power of 2):
  - err=1 for exactly 1 cycle, grant stays 0, state stays IDLE.
- GRANT:
  - grant is held constant. The hold counter decrements each cycle.
  - When the counter is 0 or release=1: next state is GAP (gap counter = GAP_CYCLES-1) if GAP_CYCLES>0, otherwise IDLE. grant=0 from that next cycle.
  - Total grant width is exactly HOLD_CYCLES cycles without release. With release, it is (cycles until release is sampled) + 1, minimum 1 cycle.
- GAP: grant=0, in_ready=0. The gap counter decrements and the state goes to IDLE when it reaches 0. The gap lasts exactly GAP_CYCLES cycles.
- release is ignored outside GRANT, including in the acceptance cycle.
- in_valid/in_idx are ignored when in_ready=0. The upstream holds them, and no queueing is performed.
- Back-to-back grants: the next acceptance happens no earlier than the first IDLE cycle. The minimum period between accepts is HOLD_CYCLES+GAP_CYCLES+1 cycles.
- grant is always zero or one-hot. A bench assertion checks $onehot0(grant) every cycle.
- Counters are 8 bits wide. Parameters outside the stated ranges are rejected by an elaboration-time check.

Decomposition:
- Package grant_decoder_pkg holds:
  - typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t
  - localparam CNT_W = 8
  - function onehot_decode(idx, n) returning a one-hot vector
- The priority encoder reuses the package for shared widths.
- No sub-module is needed: a single FSM with two down-counters. The counters may share one register because GRANT and GAP are exclusive.

Test Plan:
- Reset then idle: rst_n low 3 cycles, then high → grant=0000, in_ready=1, busy=0, err=0.
- Basic grant, defaults:
  - Stimulus: in_idx=2'b10, in_valid=1 for 1 cycle.
  - Response: grant=0100 for exactly 4 cycles starting 1 cycle after accept, then 1 gap cycle with in_ready=0, then in_ready=1.
- Early release: accept in_idx=2'b11, assert release on the 2nd grant cycle → grant=1000 for exactly 2 cycles, then 1 GAP cycle, then IDLE.
- Back-pressure:
  - Stimulus: in_valid held high with in_idx=2'b01 continuously.
  - Response: grants of 0010 repeat with a 6-cycle accept period; no grant is issued while in_ready=0.
- Async reset mid-grant: assert rst_n=0 mid-cycle during grant=0001 → grant=0000 immediately without waiting for a clock edge; after release of reset, state=IDLE.
- Out-of-range, N_OUT=3, GAP_CYCLES=0:
  - in_idx=2'b11 accepted → err high 1 cycle, grant=000, state stays IDLE.
  - Then in_idx=2'b00 → grant=001 for 4 cycles, followed directly by in_ready=1 with no gap.

Source files
------------

// File: rtl/grant_decoder_pkg.sv
// rtl/grant_decoder_pkg.sv - shared state encoding, widths and one-hot helper for the grant path
package grant_decoder_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam int CNT_W     = 8;
  localparam int MAX_OUT   = 16;
  localparam int MAX_IDX_W = 4;

  // Returns zero when idx is outside 0..n-1, so callers never see a stray bit.
  function automatic logic [MAX_OUT-1:0] onehot_decode(input logic [MAX_IDX_W-1:0] idx,
                                                       input int n);
    logic [MAX_OUT-1:0] vec;
    vec = '0;
    if (int'(idx) < n) vec[idx] = 1'b1;
    return vec;
  endfunction

endpackage

// File: rtl/grant_decoder.sv
// rtl/grant_decoder.sv - index-to-one-hot grant with fixed hold window and guard gap
module grant_decoder
  import grant_decoder_pkg::*;
#(
  parameter int N_OUT       = 4,
  parameter int IDX_W       = $clog2(N_OUT),
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] in_idx,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             early_release,
  output logic [N_OUT-1:0] grant,
  output logic             busy,
  output logic             err
);

  if (N_OUT < 2 || N_OUT > MAX_OUT) begin : g_bad_n_out
    $error("grant_decoder: N_OUT out of range 2..16");
  end
  if (HOLD_CYCLES < 1 || HOLD_CYCLES > 255) begin : g_bad_hold
    $error("grant_decoder: HOLD_CYCLES out of range 1..255");
  end
  if (GAP_CYCLES < 0 || GAP_CYCLES > 255) begin : g_bad_gap
    $error("grant_decoder: GAP_CYCLES out of range 0..255");
  end

  localparam logic [CNT_W-1:0] HOLD_INIT = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_INIT  = (GAP_CYCLES > 0) ? CNT_W'(GAP_CYCLES - 1) : '0;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [MAX_OUT-1:0] dec;
  logic               idx_ok;

  assign dec    = onehot_decode(MAX_IDX_W'(in_idx), N_OUT);
  // One extra bit keeps N_OUT itself representable when it is a power of two.
  assign idx_ok = {1'b0, in_idx} < (IDX_W + 1)'(N_OUT);

  if (N_OUT < MAX_OUT) begin : g_dec_tail
    logic unused_dec_tail;
    assign unused_dec_tail = ^dec[MAX_OUT-1:N_OUT];
  end

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);

  // One shared down-counter: GRANT uses it for the hold window, GAP for the guard gap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      grant <= '0;
      err   <= 1'b0;
    end else begin
      err <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (idx_ok) begin
              state <= GRANT;
              grant <= dec[N_OUT-1:0];
              cnt   <= HOLD_INIT;
            end else begin
              err <= 1'b1;
            end
          end
        end
        GRANT: begin
          if (cnt == '0 || early_release) begin
            grant <= '0;
            if (GAP_CYCLES > 0) begin
              state <= GAP;
              cnt   <= GAP_INIT;
            end else begin
              state <= IDLE;
              cnt   <= '0;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        GAP: begin
          if (cnt == '0) state <= IDLE;
          else           cnt   <= cnt - 1'b1;
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
          grant <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_grant_decoder.sv
// tb/tb_grant_decoder.sv - directed self-checking bench for grant_decoder
module tb_grant_decoder;

  logic       clk;
  logic       rst_n;

  logic [1:0] a_idx;
  logic       a_valid;
  logic       a_ready;
  logic       a_rel;
  logic [3:0] a_grant;
  logic       a_busy;
  logic       a_err;

  logic [1:0] b_idx;
  logic       b_valid;
  logic       b_ready;
  logic       b_rel;
  logic [2:0] b_grant;
  logic       b_busy;
  logic       b_err;

  int checks = 0;
  int errors = 0;

  grant_decoder #(.N_OUT(4), .HOLD_CYCLES(4), .GAP_CYCLES(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_idx(a_idx), .in_valid(a_valid), .in_ready(a_ready),
    .early_release(a_rel), .grant(a_grant), .busy(a_busy), .err(a_err)
  );

  grant_decoder #(.N_OUT(3), .HOLD_CYCLES(4), .GAP_CYCLES(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_idx(b_idx), .in_valid(b_valid), .in_ready(b_ready),
    .early_release(b_rel), .grant(b_grant), .busy(b_busy), .err(b_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    assert ($onehot0(a_grant) && $onehot0(b_grant)) else begin
      errors++;
      $error("FAIL onehot0 observed a=%b b=%b expected zero-or-one-hot", a_grant, b_grant);
    end
  end

  initial begin
    rst_n = 1'b0;
    a_idx = 2'd0; a_valid = 1'b0; a_rel = 1'b0;
    b_idx = 2'd0; b_valid = 1'b0; b_rel = 1'b0;

    // reset held for three cycles
    tick(); tick(); tick();
    check("rst_grant", 32'(a_grant), 32'h0);
    check("rst_ready", 32'(a_ready), 32'h1);
    check("rst_busy",  32'(a_busy),  32'h0);
    check("rst_err",   32'(a_err),   32'h0);
    rst_n = 1'b1;
    tick();
    check("idle_grant", 32'(a_grant), 32'h0);
    check("idle_ready", 32'(a_ready), 32'h1);
    check("idle_busy",  32'(a_busy),  32'h0);
    check("idle_err",   32'(b_err),   32'h0);

    // basic grant of index 2
    a_idx = 2'b10; a_valid = 1'b1;
    tick();
    a_valid = 1'b0;
    check("basic_g1", 32'(a_grant), 32'h4);
    check("basic_ready_g", 32'(a_ready), 32'h0);
    check("basic_busy_g", 32'(a_busy), 32'h1);
    for (int i = 2; i <= 4; i++) begin
      tick();
      check($sformatf("basic_g%0d", i), 32'(a_grant), 32'h4);
    end
    tick();
    check("basic_gap_grant", 32'(a_grant), 32'h0);
    check("basic_gap_ready", 32'(a_ready), 32'h0);
    check("basic_gap_busy",  32'(a_busy),  32'h1);
    tick();
    check("basic_idle_ready", 32'(a_ready), 32'h1);
    check("basic_idle_busy",  32'(a_busy),  32'h0);

    // early release on the second grant cycle
    a_idx = 2'b11; a_valid = 1'b1;
    tick();
    a_valid = 1'b0;
    check("rel_g1", 32'(a_grant), 32'h8);
    tick();
    check("rel_g2", 32'(a_grant), 32'h8);
    a_rel = 1'b1;
    tick();
    a_rel = 1'b0;
    check("rel_gap_grant", 32'(a_grant), 32'h0);
    check("rel_gap_ready", 32'(a_ready), 32'h0);
    tick();
    check("rel_idle_ready", 32'(a_ready), 32'h1);
    check("rel_idle_grant", 32'(a_grant), 32'h0);

    // held valid: accepts every 6 cycles, grant for 4, gap 1, idle 1
    a_idx = 2'b01; a_valid = 1'b1;
    tick();
    for (int k = 1; k <= 18; k++) begin
      automatic int ph = k % 6;
      check($sformatf("bp_grant_k%0d", k), 32'(a_grant), (ph >= 1 && ph <= 4) ? 32'h2 : 32'h0);
      check($sformatf("bp_ready_k%0d", k), 32'(a_ready), (ph == 0) ? 32'h1 : 32'h0);
      if (k == 18) a_valid = 1'b0;
      else tick();
    end
    tick();
    check("bp_drain_grant", 32'(a_grant), 32'h0);
    check("bp_drain_ready", 32'(a_ready), 32'h1);

    // asynchronous reset in the middle of a grant
    a_idx = 2'b00; a_valid = 1'b1;
    tick();
    a_valid = 1'b0;
    check("ar_grant", 32'(a_grant), 32'h1);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_grant_cleared", 32'(a_grant), 32'h0);
    check("ar_busy_cleared",  32'(a_busy),  32'h0);
    check("ar_ready",         32'(a_ready), 32'h1);
    tick();
    rst_n = 1'b1;
    tick();
    check("ar_post_grant", 32'(a_grant), 32'h0);
    check("ar_post_busy",  32'(a_busy),  32'h0);
    tick();
    check("ar_no_resume",  32'(a_grant), 32'h0);

    // N_OUT=3, no gap: out-of-range index then a normal grant
    b_idx = 2'b11; b_valid = 1'b1;
    tick();
    b_valid = 1'b0;
    check("oor_err",   32'(b_err),   32'h1);
    check("oor_grant", 32'(b_grant), 32'h0);
    check("oor_busy",  32'(b_busy),  32'h0);
    check("oor_ready", 32'(b_ready), 32'h1);
    tick();
    check("oor_err_pulse", 32'(b_err), 32'h0);
    b_idx = 2'b00; b_valid = 1'b1;
    tick();
    b_valid = 1'b0;
    check("b_g1", 32'(b_grant), 32'h1);
    check("b_err_ok", 32'(b_err), 32'h0);
    for (int i = 2; i <= 4; i++) begin
      tick();
      check($sformatf("b_g%0d", i), 32'(b_grant), 32'h1);
      check($sformatf("b_ready_g%0d", i), 32'(b_ready), 32'h0);
    end
    tick();
    check("b_nogap_grant", 32'(b_grant), 32'h0);
    check("b_nogap_ready", 32'(b_ready), 32'h1);
    check("b_nogap_busy",  32'(b_busy),  32'h0);

    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
